// File: rtl/dvl_pkg.sv
// Shared types for the DVL transducer drive path.
package dvl_pkg;

  // Command consumed by h_bridge.
  typedef enum logic [1:0] {
    HIGHZ = 2'b00,
    DAMP  = 2'b01,
    OSCL  = 2'b10
  } h_bridge_state_t;

endpackage

// File: rtl/ping_sequencer.sv
// Per-ping drive schedule: transmit burst, active damping, receiver blanking, listen window.
// Every output is registered and is computed from the next FSM state.
module ping_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         burst_len,
  input  logic [CNT_W-1:0]         damp_len,
  input  logic [CNT_W-1:0]         blank_len,
  input  logic [CNT_W-1:0]         listen_len,
  output dvl_pkg::h_bridge_state_t state,
  output logic                     busy,
  output logic                     listen,
  output logic                     done,
  output logic                     aborted,
  output logic [15:0]              ping_count
);

  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StDamp,
    StBlank,
    StListen
  } fsm_e;

  // Phase indices used when searching for the next nonzero phase.
  localparam logic [2:0] PhTx     = 3'd0;
  localparam logic [2:0] PhDamp   = 3'd1;
  localparam logic [2:0] PhBlank  = 3'd2;
  localparam logic [2:0] PhListen = 3'd3;
  localparam logic [2:0] PhNone   = 3'd4;

  fsm_e                     fsm_q, fsm_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         damp_len_q, damp_len_d;
  logic [CNT_W-1:0]         blank_len_q, blank_len_d;
  logic [CNT_W-1:0]         listen_len_q, listen_len_d;
  logic                     abort_pend_q, abort_pend_d;
  dvl_pkg::h_bridge_state_t state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     listen_q, listen_d;
  logic                     done_q, done_d;
  logic                     aborted_q, aborted_d;
  logic [15:0]              ping_count_q, ping_count_d;

  // Lengths seen by the phase search: live inputs in IDLE (they latch this edge), else latched.
  logic [CNT_W-1:0] len_sel [4];
  logic [3:0]       len_nz;
  logic             seek;
  logic [2:0]       seek_from;
  logic [2:0]       next_ph;

  // Lowest-index phase at or after 'from' whose length is nonzero; PhNone if none remain.
  function automatic logic [2:0] first_nz(input logic [3:0] nz, input logic [2:0] from);
    logic [2:0] idx;
    idx = PhNone;
    for (int i = 3; i >= 0; i--) begin
      if (nz[i] && (3'(i) >= from)) idx = 3'(i);
    end
    return idx;
  endfunction

  // Select the length set the phase search works from.
  always_comb begin
    len_sel[0] = burst_len;
    len_sel[1] = (fsm_q == StIdle) ? damp_len   : damp_len_q;
    len_sel[2] = (fsm_q == StIdle) ? blank_len  : blank_len_q;
    len_sel[3] = (fsm_q == StIdle) ? listen_len : listen_len_q;
    for (int i = 0; i < 4; i++) begin
      len_nz[i] = (len_sel[i] != '0);
    end
  end

  // Next-state logic: phase countdown, abort handling, skip of zero-length phases.
  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    damp_len_d   = damp_len_q;
    blank_len_d  = blank_len_q;
    listen_len_d = listen_len_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    ping_count_d = ping_count_q;
    seek         = 1'b0;
    seek_from    = PhTx;

    unique case (fsm_q)
      StIdle: begin
        // start beats a simultaneous abort; abort alone does nothing here.
        if (start) begin
          damp_len_d   = damp_len;
          blank_len_d  = blank_len;
          listen_len_d = listen_len;
          abort_pend_d = 1'b0;
          seek         = 1'b1;
          seek_from    = PhTx;
        end
      end

      StTx: begin
        if (abort) begin
          // Never leave OSCL straight to HIGHZ when damping is configured.
          if (damp_len_q != '0) begin
            fsm_d        = StDamp;
            cnt_d        = damp_len_q - CNT_W'(1);
            abort_pend_d = 1'b1;
          end else begin
            fsm_d     = StIdle;
            cnt_d     = '0;
            aborted_d = 1'b1;
          end
        end else if (cnt_q == '0) begin
          seek      = 1'b1;
          seek_from = PhDamp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      StDamp: begin
        // Damping always runs to completion; an abort only changes where it goes next.
        if (cnt_q == '0) begin
          if (abort_pend_q || abort) begin
            fsm_d     = StIdle;
            cnt_d     = '0;
            aborted_d = 1'b1;
          end else begin
            seek      = 1'b1;
            seek_from = PhBlank;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (abort) abort_pend_d = 1'b1;
        end
      end

      StBlank: begin
        if (abort) begin
          fsm_d     = StIdle;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          seek      = 1'b1;
          seek_from = PhListen;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      StListen: begin
        if (abort) begin
          fsm_d     = StIdle;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          seek      = 1'b1;
          seek_from = PhNone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        fsm_d = StIdle;
        cnt_d = '0;
      end
    endcase

    next_ph = first_nz(len_nz, seek_from);

    // Enter the next nonzero phase, or finish the ping if none remain.
    if (seek) begin
      unique case (next_ph)
        PhTx: begin
          fsm_d = StTx;
          cnt_d = len_sel[0] - CNT_W'(1);
        end
        PhDamp: begin
          fsm_d = StDamp;
          cnt_d = len_sel[1] - CNT_W'(1);
        end
        PhBlank: begin
          fsm_d = StBlank;
          cnt_d = len_sel[2] - CNT_W'(1);
        end
        PhListen: begin
          fsm_d = StListen;
          cnt_d = len_sel[3] - CNT_W'(1);
        end
        default: begin
          fsm_d        = StIdle;
          cnt_d        = '0;
          done_d       = 1'b1;
          ping_count_d = ping_count_q + 16'd1;
        end
      endcase
    end

    unique case (fsm_d)
      StTx:    state_d = dvl_pkg::OSCL;
      StDamp:  state_d = dvl_pkg::DAMP;
      default: state_d = dvl_pkg::HIGHZ;
    endcase
    busy_d   = (fsm_d != StIdle);
    listen_d = (fsm_d == StListen);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= StIdle;
      cnt_q        <= '0;
      damp_len_q   <= '0;
      blank_len_q  <= '0;
      listen_len_q <= '0;
      abort_pend_q <= 1'b0;
      state_q      <= dvl_pkg::HIGHZ;
      busy_q       <= 1'b0;
      listen_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ping_count_q <= 16'd0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      damp_len_q   <= damp_len_d;
      blank_len_q  <= blank_len_d;
      listen_len_q <= listen_len_d;
      abort_pend_q <= abort_pend_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      listen_q     <= listen_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      ping_count_q <= ping_count_d;
    end
  end

  assign state      = state_q;
  assign busy       = busy_q;
  assign listen     = listen_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign ping_count = ping_count_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Bench for ping_sequencer: stimulus queues per-cycle expected outputs, a monitor checks them.
module tb_ping_sequencer;
  import dvl_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W-1:0] damp_len;
  logic [CNT_W-1:0] blank_len;
  logic [CNT_W-1:0] listen_len;
  h_bridge_state_t  state;
  logic             busy;
  logic             listen;
  logic             done;
  logic             aborted;
  logic [15:0]      ping_count;

  ping_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .damp_len   (damp_len),
    .blank_len  (blank_len),
    .listen_len (listen_len),
    .state      (state),
    .busy       (busy),
    .listen     (listen),
    .done       (done),
    .aborted    (aborted),
    .ping_count (ping_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    h_bridge_state_t st;
    logic            busy;
    logic            listen;
    logic            done;
    logic            aborted;
    logic [15:0]     pc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the outputs of the current cycle with the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_sample cyc=%0d now=%0d", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (state !== e.st || busy !== e.busy || listen !== e.listen || done !== e.done ||
          aborted !== e.aborted || ping_count !== e.pc) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d got st=%0d busy=%b listen=%b done=%b aborted=%b pc=%h want st=%0d busy=%b listen=%b done=%b aborted=%b pc=%h",
                 cyc, state, busy, listen, done, aborted, ping_count,
                 e.st, e.busy, e.listen, e.done, e.aborted, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic ex(input int c, input h_bridge_state_t s, input logic b, input logic l,
                    input logic d, input logic a, input logic [15:0] pc);
    exp_t e;
    e.cyc = c; e.st = s; e.busy = b; e.listen = l; e.done = d; e.aborted = a; e.pc = pc;
    q.push_back(e);
  endtask

  task automatic exr(input int c_from, input int c_to, input h_bridge_state_t s,
                     input logic b, input logic l, input logic [15:0] pc);
    for (int c = c_from; c <= c_to; c++) ex(c, s, b, l, 1'b0, 1'b0, pc);
  endtask

  task automatic lens(input logic [15:0] b, input logic [15:0] d, input logic [15:0] k,
                      input logic [15:0] l);
    burst_len = b; damp_len = d; blank_len = k; listen_len = l;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    lens(16'd0, 16'd0, 16'd0, 16'd0);
    step(); step();

    // Reset values, then abort in IDLE has no effect.
    c0 = cyc;
    ex(c0 + 1, HIGHZ, 0, 0, 0, 0, 16'd0);
    wait_to(c0 + 1);
    rst = 1'b0; abort = 1'b1;
    ex(c0 + 2, HIGHZ, 0, 0, 0, 0, 16'd0);
    ex(c0 + 3, HIGHZ, 0, 0, 0, 0, 16'd0);
    wait_to(c0 + 3);
    abort = 1'b0;

    // Normal ping 4/3/2/5; inputs cleared after latching.
    c0 = cyc; lens(16'd4, 16'd3, 16'd2, 16'd5); start = 1'b1;
    exr(c0 + 1, c0 + 4, OSCL, 1, 0, 16'd0);
    exr(c0 + 5, c0 + 7, DAMP, 1, 0, 16'd0);
    exr(c0 + 8, c0 + 9, HIGHZ, 1, 0, 16'd0);
    exr(c0 + 10, c0 + 14, HIGHZ, 1, 1, 16'd0);
    ex(c0 + 15, HIGHZ, 0, 0, 1, 0, 16'd1);
    ex(c0 + 16, HIGHZ, 0, 0, 0, 0, 16'd1);
    step(); start = 1'b0; lens(16'd0, 16'd0, 16'd0, 16'd0);
    wait_to(c0 + 16);

    // Skipped phases 0/3/0/2.
    c0 = cyc; lens(16'd0, 16'd3, 16'd0, 16'd2); start = 1'b1;
    exr(c0 + 1, c0 + 3, DAMP, 1, 0, 16'd1);
    exr(c0 + 4, c0 + 5, HIGHZ, 1, 1, 16'd1);
    ex(c0 + 6, HIGHZ, 0, 0, 1, 0, 16'd2);
    ex(c0 + 7, HIGHZ, 0, 0, 0, 0, 16'd2);
    step(); start = 1'b0;
    wait_to(c0 + 7);

    // All lengths zero: done next cycle, never busy.
    c0 = cyc; lens(16'd0, 16'd0, 16'd0, 16'd0); start = 1'b1;
    ex(c0 + 1, HIGHZ, 0, 0, 1, 0, 16'd3);
    ex(c0 + 2, HIGHZ, 0, 0, 0, 0, 16'd3);
    step(); start = 1'b0;
    wait_to(c0 + 2);

    // Abort in TX at cycle 5: full damp, then aborted.
    c0 = cyc; lens(16'd10, 16'd4, 16'd2, 16'd8); start = 1'b1;
    exr(c0 + 1, c0 + 5, OSCL, 1, 0, 16'd3);
    exr(c0 + 6, c0 + 9, DAMP, 1, 0, 16'd3);
    ex(c0 + 10, HIGHZ, 0, 0, 0, 1, 16'd3);
    ex(c0 + 11, HIGHZ, 0, 0, 0, 0, 16'd3);
    step(); start = 1'b0;
    wait_to(c0 + 5); abort = 1'b1;
    step(); abort = 1'b0;
    wait_to(c0 + 11);

    // Abort in DAMP at cycle 12: damping finishes, blank/listen dropped.
    c0 = cyc; start = 1'b1;
    exr(c0 + 1, c0 + 10, OSCL, 1, 0, 16'd3);
    exr(c0 + 11, c0 + 14, DAMP, 1, 0, 16'd3);
    ex(c0 + 15, HIGHZ, 0, 0, 0, 1, 16'd3);
    ex(c0 + 16, HIGHZ, 0, 0, 0, 0, 16'd3);
    step(); start = 1'b0;
    wait_to(c0 + 12); abort = 1'b1;
    step(); abort = 1'b0;
    wait_to(c0 + 16);

    // Abort in LISTEN at cycle 20: IDLE next cycle.
    c0 = cyc; start = 1'b1;
    exr(c0 + 1, c0 + 10, OSCL, 1, 0, 16'd3);
    exr(c0 + 11, c0 + 14, DAMP, 1, 0, 16'd3);
    exr(c0 + 15, c0 + 16, HIGHZ, 1, 0, 16'd3);
    exr(c0 + 17, c0 + 20, HIGHZ, 1, 1, 16'd3);
    ex(c0 + 21, HIGHZ, 0, 0, 0, 1, 16'd3);
    ex(c0 + 22, HIGHZ, 0, 0, 0, 0, 16'd3);
    step(); start = 1'b0;
    wait_to(c0 + 20); abort = 1'b1;
    step(); abort = 1'b0;
    wait_to(c0 + 22);

    // Abort in TX with zero damp: straight to IDLE.
    c0 = cyc; lens(16'd3, 16'd0, 16'd2, 16'd2); start = 1'b1;
    exr(c0 + 1, c0 + 2, OSCL, 1, 0, 16'd3);
    ex(c0 + 3, HIGHZ, 0, 0, 0, 1, 16'd3);
    ex(c0 + 4, HIGHZ, 0, 0, 0, 0, 16'd3);
    step(); start = 1'b0;
    wait_to(c0 + 2); abort = 1'b1;
    step(); abort = 1'b0;
    wait_to(c0 + 4);

    // start and abort together in IDLE: start wins.
    c0 = cyc; lens(16'd1, 16'd0, 16'd0, 16'd1); start = 1'b1; abort = 1'b1;
    ex(c0 + 1, OSCL, 1, 0, 0, 0, 16'd3);
    ex(c0 + 2, HIGHZ, 1, 1, 0, 0, 16'd3);
    ex(c0 + 3, HIGHZ, 0, 0, 1, 0, 16'd4);
    ex(c0 + 4, HIGHZ, 0, 0, 0, 0, 16'd4);
    step(); start = 1'b0; abort = 1'b0;
    wait_to(c0 + 4);

    // start held through a ping with changing lengths: re-arm on the done cycle.
    c0 = cyc; lens(16'd2, 16'd1, 16'd1, 16'd2); start = 1'b1;
    exr(c0 + 1, c0 + 2, OSCL, 1, 0, 16'd4);
    ex(c0 + 3, DAMP, 1, 0, 0, 0, 16'd4);
    ex(c0 + 4, HIGHZ, 1, 0, 0, 0, 16'd4);
    exr(c0 + 5, c0 + 6, HIGHZ, 1, 1, 16'd4);
    ex(c0 + 7, HIGHZ, 0, 0, 1, 0, 16'd5);
    ex(c0 + 8, OSCL, 1, 0, 0, 0, 16'd5);
    ex(c0 + 9, DAMP, 1, 0, 0, 0, 16'd5);
    ex(c0 + 10, HIGHZ, 1, 1, 0, 0, 16'd5);
    ex(c0 + 11, HIGHZ, 0, 0, 1, 0, 16'd6);
    ex(c0 + 12, HIGHZ, 0, 0, 0, 0, 16'd6);
    step(); lens(16'd1, 16'd1, 16'd0, 16'd1);
    wait_to(c0 + 11); start = 1'b0;
    wait_to(c0 + 12);

    // rst during DAMP, then a full normal ping.
    c0 = cyc; lens(16'd2, 16'd5, 16'd1, 16'd1); start = 1'b1;
    exr(c0 + 1, c0 + 2, OSCL, 1, 0, 16'd6);
    exr(c0 + 3, c0 + 4, DAMP, 1, 0, 16'd6);
    ex(c0 + 5, HIGHZ, 0, 0, 0, 0, 16'd0);
    ex(c0 + 6, HIGHZ, 0, 0, 0, 0, 16'd0);
    step(); start = 1'b0;
    wait_to(c0 + 4); rst = 1'b1;
    step(); rst = 1'b0;
    wait_to(c0 + 6);
    c0 = cyc; lens(16'd1, 16'd1, 16'd1, 16'd1); start = 1'b1;
    ex(c0 + 1, OSCL, 1, 0, 0, 0, 16'd0);
    ex(c0 + 2, DAMP, 1, 0, 0, 0, 16'd0);
    ex(c0 + 3, HIGHZ, 1, 0, 0, 0, 16'd0);
    ex(c0 + 4, HIGHZ, 1, 1, 0, 0, 16'd0);
    ex(c0 + 5, HIGHZ, 0, 0, 1, 0, 16'd1);
    ex(c0 + 6, HIGHZ, 0, 0, 0, 0, 16'd1);
    step(); start = 1'b0;
    wait_to(c0 + 6);

    // Zero-length pings back to back up to 0xFFFF, then one more wraps to 0.
    n = 65534;
    c0 = cyc; lens(16'd0, 16'd0, 16'd0, 16'd0); start = 1'b1;
    ex(c0 + 1, HIGHZ, 0, 0, 1, 0, 16'd2);
    wait_to(c0 + n); start = 1'b0;
    ex(c0 + n, HIGHZ, 0, 0, 1, 0, 16'hFFFF);
    ex(c0 + n + 1, HIGHZ, 0, 0, 0, 0, 16'hFFFF);
    wait_to(c0 + n + 1);
    c0 = cyc; lens(16'd1, 16'd0, 16'd0, 16'd0); start = 1'b1;
    ex(c0 + 1, OSCL, 1, 0, 0, 0, 16'hFFFF);
    ex(c0 + 2, HIGHZ, 0, 0, 1, 0, 16'h0000);
    ex(c0 + 3, HIGHZ, 0, 0, 0, 0, 16'h0000);
    step(); start = 1'b0;
    wait_to(c0 + 3);
    step();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d want=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
